// File: rtl/instr_loader.sv
// instr_loader: framed byte-stream boot loader feeding the cpu init port.
// Holds the cpu in reset until the image checksum verifies.
module instr_loader #(
    parameter logic [31:0] ADDR_BASE = 32'h0,
    parameter int unsigned MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic        reload,
    output logic        initialize,
    output logic [31:0] instruction_initialize_address,
    output logic [31:0] instruction_initialize_data,
    output logic        cpu_rst,
    output logic        done,
    output logic        error
);

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_WORD,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] k_q, k_d;
    logic [1:0]  bidx_q, bidx_d;
    logic [23:0] shift_q, shift_d;
    logic [7:0]  xor_q, xor_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;

    logic        loading;
    logic        accept;
    logic [15:0] k_inc;
    logic [15:0] cnt_full;

    assign loading  = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                      (state_q == S_WORD)   || (state_q == S_CSUM);
    assign accept   = byte_valid && loading;
    assign k_inc    = k_q + 16'd1;
    assign cnt_full = {cnt_q[15:8], byte_data};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_CNT_HI;
            cnt_q   <= '0;
            k_q     <= '0;
            bidx_q  <= '0;
            shift_q <= '0;
            xor_q   <= '0;
            addr_q  <= ADDR_BASE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            bidx_q  <= bidx_d;
            shift_q <= shift_d;
            xor_q   <= xor_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        bidx_d  = bidx_q;
        shift_d = shift_q;
        xor_d   = xor_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            S_CNT_HI: begin
                if (accept) begin
                    cnt_d[15:8] = byte_data;
                    xor_d       = byte_data;
                    state_d     = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (accept) begin
                    cnt_d[7:0] = byte_data;
                    xor_d      = xor_q ^ byte_data;
                    k_d        = '0;
                    bidx_d     = '0;
                    if ({1'b0, cnt_full} > MAX_N)
                        state_d = S_ERR;
                    else if (cnt_full == 16'd0)
                        state_d = S_CSUM;
                    else
                        state_d = S_WORD;
                end
            end
            S_WORD: begin
                if (accept) begin
                    xor_d  = xor_q ^ byte_data;
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        // Big-endian: first byte ends up in bits 31:24.
                        data_d = {shift_q, byte_data};
                        addr_d = ADDR_BASE + {14'd0, k_q, 2'b00};
                        k_d    = k_inc;
                        if (k_inc == cnt_q)
                            state_d = S_CSUM;
                    end else begin
                        shift_d = {shift_q[15:0], byte_data};
                    end
                end
            end
            S_CSUM: begin
                if (accept)
                    state_d = (byte_data == xor_q) ? S_RUN : S_ERR;
            end
            S_RUN, S_ERR: begin
                if (reload) begin
                    state_d = S_CNT_HI;
                    k_d     = '0;
                    xor_d   = '0;
                    bidx_d  = '0;
                    addr_d  = ADDR_BASE;
                end
            end
            default: state_d = S_CNT_HI;
        endcase
    end

    assign byte_ready = loading;
    assign initialize = loading;
    assign cpu_rst    = (state_q != S_RUN);
    assign done       = (state_q == S_RUN);
    assign error      = (state_q == S_ERR);

    assign instruction_initialize_address = addr_q;
    assign instruction_initialize_data    = data_q;

endmodule
